// File: rtl/multicycle_controller_pkg.sv
// Shared constants and types for the MIPS-subset controllers.
// Contents:
//   state_t    - sequencing states of the multi-cycle controller
//   OP_* / FUNC_*  - opcode and R-type func field values
//   ALU_*      - ALUop codes driven to the shared ALU
//   SRCB_*     - ALUsrcB mux encodings
//   PCSEL_*    - PCselect mux encodings
//   ctrl_t     - bundle of every control output, used to build outputs in one place
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_RWB,
        S_IMMEX,
        S_IMMWB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR,
        S_LUI
    } state_t;

    typedef logic [3:0] alu_op_t;
    typedef logic [1:0] srcb_t;
    typedef logic [1:0] pcsel_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // R-type func codes (IR[5:0])
    localparam logic [5:0] FUNC_JR   = 6'd8;
    localparam logic [5:0] FUNC_MFHI = 6'd16;
    localparam logic [5:0] FUNC_MFLO = 6'd18;
    localparam logic [5:0] FUNC_MULT = 6'd24;
    localparam logic [5:0] FUNC_DIV  = 6'd26;
    localparam logic [5:0] FUNC_ADD  = 6'd32;
    localparam logic [5:0] FUNC_SUB  = 6'd34;
    localparam logic [5:0] FUNC_AND  = 6'd36;
    localparam logic [5:0] FUNC_OR   = 6'd37;
    localparam logic [5:0] FUNC_XOR  = 6'd38;
    localparam logic [5:0] FUNC_SLT  = 6'd42;

    // ALU operation codes
    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_OR   = 4'd2;
    localparam alu_op_t ALU_AND  = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_SLT  = 4'd5;
    localparam alu_op_t ALU_MULT = 4'd6;
    localparam alu_op_t ALU_MFHI = 4'd7;
    localparam alu_op_t ALU_MFLO = 4'd8;
    localparam alu_op_t ALU_DIV  = 4'd9;

    // ALU B operand select
    localparam srcb_t SRCB_B       = 2'b00;
    localparam srcb_t SRCB_FOUR    = 2'b01;
    localparam srcb_t SRCB_IMM     = 2'b10;
    localparam srcb_t SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam pcsel_t PCSEL_ALU    = 2'b00;
    localparam pcsel_t PCSEL_ALUOUT = 2'b01;
    localparam pcsel_t PCSEL_A      = 2'b10;
    localparam pcsel_t PCSEL_JUMP   = 2'b11;

    typedef struct packed {
        logic    pc_write;
        logic    iord;
        logic    mem_read;
        logic    mem_write;
        logic    ir_write;
        logic    reg_write;
        logic    reg_dst;
        logic    mem_to_reg;
        logic    is_jal;
        logic    is_lui;
        logic    hilo_write;
        logic    alu_src_a;
        srcb_t   alu_src_b;
        alu_op_t alu_op;
        pcsel_t  pc_select;
        logic    done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath.
//   opcode/func/zero  - instruction fields and ALU zero flag, from the datapath
//   PCWrite..done     - enables and mux selects, from the controller
// Modports: master = controller side, slave = datapath side.
interface multicycle_controller_if;
    import multicycle_controller_pkg::*;

    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;

    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemToReg;
    logic       IsJal;
    logic       IsLui;
    logic       HiLoWrite;
    logic       ALUsrcA;
    srcb_t      ALUsrcB;
    alu_op_t    ALUop;
    pcsel_t     PCselect;
    logic       done;

    modport master (
        input  opcode, func, zero,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
               MemToReg, IsJal, IsLui, HiLoWrite, ALUsrcA, ALUsrcB, ALUop,
               PCselect, done
    );

    modport slave (
        output opcode, func, zero,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
               MemToReg, IsJal, IsLui, HiLoWrite, ALUsrcA, ALUsrcB, ALUop,
               PCselect, done
    );
endinterface

// File: rtl/multicycle_controller_alu_func_decode.sv
// R-type func field decoder.
//   func     in  6  IR[5:0]
//   alu_op   out 4  ALU operation for the func (ADD when not an ALU func)
//   is_hilo  out 1  func writes HI/LO (mult/div) instead of the register file
//   is_alu   out 1  func is one of the supported ALU / HI-LO operations
module alu_func_decode
    import multicycle_controller_pkg::*;
(
    input  logic [5:0] func,
    output alu_op_t    alu_op,
    output logic       is_hilo,
    output logic       is_alu
);

    always_comb begin
        alu_op  = ALU_ADD;
        is_hilo = 1'b0;
        is_alu  = 1'b1;
        case (func)
            FUNC_ADD:  alu_op = ALU_ADD;
            FUNC_SUB:  alu_op = ALU_SUB;
            FUNC_AND:  alu_op = ALU_AND;
            FUNC_OR:   alu_op = ALU_OR;
            FUNC_XOR:  alu_op = ALU_XOR;
            FUNC_SLT:  alu_op = ALU_SLT;
            FUNC_MFHI: alu_op = ALU_MFHI;
            FUNC_MFLO: alu_op = ALU_MFLO;
            FUNC_MULT: begin
                alu_op  = ALU_MULT;
                is_hilo = 1'b1;
            end
            FUNC_DIV: begin
                alu_op  = ALU_DIV;
                is_hilo = 1'b1;
            end
            default:   is_alu = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the multi-cycle MIPS-subset datapath.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset; returns to FETCH and masks all
//           state-changing strobes while held
//   ctrl  - control bundle (master side): opcode/func/zero in, every datapath
//           enable and mux select out
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    multicycle_controller_if.master ctrl
);

    state_t  state_q;
    state_t  state_d;
    ctrl_t   c;

    alu_op_t func_alu_op;
    logic    func_is_hilo;
    logic    func_is_alu;

    alu_func_decode u_alu_func_decode (
        .func    (ctrl.func),
        .alu_op  (func_alu_op),
        .is_hilo (func_is_hilo),
        .is_alu  (func_is_alu)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl.opcode)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (ctrl.func == FUNC_JR) begin
                            state_d = S_JR;
                        end else if (func_is_alu) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d = S_FETCH;   // unsupported func: NOP
                        end
                    end
                    OP_ADDI, OP_SLTI: state_d = S_IMMEX;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    OP_LUI:           state_d = S_LUI;
                    default:          state_d = S_FETCH;   // unsupported opcode: NOP
                endcase
            end
            S_MEMADR: state_d = (ctrl.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = func_is_hilo ? S_FETCH : S_RWB;
            S_IMMEX:  state_d = S_IMMWB;
            default:  state_d = S_FETCH;   // all write-back / final states
        endcase
    end

    // Output logic
    always_comb begin
        c = '0;
        case (state_q)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut.
                c.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_B;
                c.alu_op     = func_alu_op;
                c.hilo_write = func_is_hilo;
            end
            S_RWB: begin
                // ALUop stays on the func operation so the ALU result is
                // still valid for the register write.
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = func_alu_op;
            end
            S_IMMEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = (ctrl.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_IMMWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_SUB;
                c.pc_select = PCSEL_ALUOUT;
                c.pc_write  = (ctrl.opcode == OP_BEQ) ? ctrl.zero : ~ctrl.zero;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_select = PCSEL_JUMP;
            end
            S_JAL: begin
                c.reg_write = 1'b1;
                c.is_jal    = 1'b1;
                c.pc_write  = 1'b1;
                c.pc_select = PCSEL_JUMP;
            end
            S_JR: begin
                c.pc_write  = 1'b1;
                c.pc_select = PCSEL_A;
            end
            S_LUI: begin
                c.reg_write = 1'b1;
                c.is_lui    = 1'b1;
            end
            default: c = '0;
        endcase
        // Final cycle of any instruction is the one that returns to FETCH.
        c.done = (state_q != S_FETCH) && (state_d == S_FETCH);
    end

    // Strobes that change architectural state are masked during reset so an
    // abandoned instruction never completes a partial write.
    assign ctrl.PCWrite   = c.pc_write   & ~rst;
    assign ctrl.IRWrite   = c.ir_write   & ~rst;
    assign ctrl.RegWrite  = c.reg_write  & ~rst;
    assign ctrl.MemWrite  = c.mem_write  & ~rst;
    assign ctrl.HiLoWrite = c.hilo_write & ~rst;
    assign ctrl.done      = c.done       & ~rst;

    assign ctrl.IorD      = c.iord;
    assign ctrl.MemRead   = c.mem_read;
    assign ctrl.RegDst    = c.reg_dst;
    assign ctrl.MemToReg  = c.mem_to_reg;
    assign ctrl.IsJal     = c.is_jal;
    assign ctrl.IsLui     = c.is_lui;
    assign ctrl.ALUsrcA   = c.alu_src_a;
    assign ctrl.ALUsrcB   = c.alu_src_b;
    assign ctrl.ALUop     = c.alu_op;
    assign ctrl.PCselect  = c.pc_select;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller. The driver issues one
// instruction per FETCH and pushes an instruction-level summary predicted from
// the opcode/func/zero rules; the monitor folds the observed per-cycle outputs
// of each instruction into the same summary and compares when done is seen.
module tb_multicycle_controller;

    logic clk;
    logic rst;

    multicycle_controller_if ifc ();

    multicycle_controller dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int op;
        int fn;
        int cycles;
        int n_irw;
        int n_pcw;
        int n_mrd;
        int n_mwr;
        int n_hilo;
        int n_regw;
        int n_iord;
        int wb_dst;
        int wb_mem;
        int wb_jal;
        int wb_lui;
        int wb_alu;
        int a_op;
        int a_bsrc;
        int pcsel;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ALU code for a supported R-type func, -1 otherwise.
    function automatic int rfunc_op(int fn);
        case (fn)
            32: return 0;
            34: return 1;
            37: return 2;
            36: return 3;
            38: return 4;
            42: return 5;
            24: return 6;
            16: return 7;
            18: return 8;
            26: return 9;
            default: return -1;
        endcase
    endfunction

    // Instruction-level reference: what one instruction should do in total.
    function automatic rec_t model(int op, int fn, bit z);
        rec_t r;
        int   k;
        bit   taken;
        r = '{default: 0};
        r.op = op; r.fn = fn;
        // Every instruction begins with one fetch: read, IR load, PC+4.
        r.n_irw = 1; r.n_pcw = 1; r.n_mrd = 1;
        r.a_op = -1; r.a_bsrc = -1; r.pcsel = 0;
        case (op)
            35: begin
                r.cycles = 5; r.n_regw = 1; r.n_mrd = 2; r.n_iord = 1;
                r.wb_mem = 1; r.a_op = 0; r.a_bsrc = 2;
            end
            43: begin
                r.cycles = 4; r.n_mwr = 1; r.n_iord = 1; r.a_op = 0; r.a_bsrc = 2;
            end
            0: begin
                k = rfunc_op(fn);
                if (fn == 8) begin
                    r.cycles = 3; r.n_pcw = 2; r.pcsel = 2;
                end else if (k < 0) begin
                    r.cycles = 2;
                end else if (k == 6 || k == 9) begin
                    r.cycles = 3; r.n_hilo = 1; r.a_op = k; r.a_bsrc = 0;
                end else begin
                    r.cycles = 4; r.n_regw = 1; r.wb_dst = 1; r.wb_alu = k;
                    r.a_op = k; r.a_bsrc = 0;
                end
            end
            8, 10: begin
                r.cycles = 4; r.n_regw = 1; r.a_op = (op == 10) ? 5 : 0; r.a_bsrc = 2;
            end
            4, 5: begin
                taken = (op == 4) ? z : !z;
                r.cycles = 3; r.a_op = 1; r.a_bsrc = 0;
                if (taken) begin
                    r.n_pcw = 2; r.pcsel = 1;
                end
            end
            2: begin
                r.cycles = 3; r.n_pcw = 2; r.pcsel = 3;
            end
            3: begin
                r.cycles = 3; r.n_pcw = 2; r.pcsel = 3; r.n_regw = 1; r.wb_jal = 1;
            end
            15: begin
                r.cycles = 3; r.n_regw = 1; r.wb_lui = 1;
            end
            default: r.cycles = 2;
        endcase
        return r;
    endfunction

    // ---------------- Monitor ----------------
    rec_t obs;
    bit   in_instr = 1'b0;

    task automatic compare_rec(rec_t e, rec_t o);
        string p;
        p = $sformatf("op%0d/fn%0d", e.op, e.fn);
        chk({p, " cycles"},  o.cycles, e.cycles);
        chk({p, " irwrite"}, o.n_irw,  e.n_irw);
        chk({p, " pcwrite"}, o.n_pcw,  e.n_pcw);
        chk({p, " memread"}, o.n_mrd,  e.n_mrd);
        chk({p, " memwrite"},o.n_mwr,  e.n_mwr);
        chk({p, " hilo"},    o.n_hilo, e.n_hilo);
        chk({p, " regwrite"},o.n_regw, e.n_regw);
        chk({p, " iord"},    o.n_iord, e.n_iord);
        chk({p, " regdst"},  o.wb_dst, e.wb_dst);
        chk({p, " memtoreg"},o.wb_mem, e.wb_mem);
        chk({p, " isjal"},   o.wb_jal, e.wb_jal);
        chk({p, " islui"},   o.wb_lui, e.wb_lui);
        chk({p, " wb_aluop"},o.wb_alu, e.wb_alu);
        chk({p, " exec_aluop"}, o.a_op, e.a_op);
        chk({p, " exec_srcb"},  o.a_bsrc, e.a_bsrc);
        chk({p, " pcselect"},   o.pcsel, e.pcsel);
    endtask

    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_gated_strobes",
                    int'({ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.MemWrite,
                          ifc.HiLoWrite, ifc.done}), 0);
                if (in_instr) begin
                    in_instr = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end else begin
                if (!in_instr) begin
                    chk("start_with_fetch", int'(ifc.IRWrite), 1);
                    in_instr = 1'b1;
                    obs = '{default: 0};
                    obs.a_op = -1; obs.a_bsrc = -1;
                end
                obs.cycles++;
                if (ifc.IRWrite)  obs.n_irw++;
                if (ifc.MemRead)  obs.n_mrd++;
                if (ifc.MemWrite) obs.n_mwr++;
                if (ifc.HiLoWrite) obs.n_hilo++;
                if ((ifc.MemRead || ifc.MemWrite) && ifc.IorD) obs.n_iord++;
                if (ifc.PCWrite) begin
                    obs.n_pcw++;
                    obs.pcsel = int'(ifc.PCselect);
                end
                if (ifc.RegWrite) begin
                    obs.n_regw++;
                    obs.wb_dst = int'(ifc.RegDst);
                    obs.wb_mem = int'(ifc.MemToReg);
                    obs.wb_jal = int'(ifc.IsJal);
                    obs.wb_lui = int'(ifc.IsLui);
                    obs.wb_alu = int'(ifc.ALUop);
                end
                if (ifc.ALUsrcA) begin
                    obs.a_op   = int'(ifc.ALUop);
                    obs.a_bsrc = int'(ifc.ALUsrcB);
                end
                if (ifc.done) begin
                    in_instr = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("done_without_expected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        compare_rec(e, obs);
                    end
                end else if (obs.cycles > 12) begin
                    chk("instr_cycle_budget", obs.cycles, 12);
                    in_instr = 1'b0;
                end
            end
        end
    end

    // ---------------- Driver ----------------
    task automatic issue(int op, int fn, bit z);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.IRWrite && !rst) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            chk("fetch_wait_timeout", 0, 1);
        end else begin
            ifc.opcode = 6'(op);
            ifc.func   = 6'(fn);
            ifc.zero   = z;
            exp_q.push_back(model(op, fn, z));
        end
    endtask

    task automatic reset_mid_memrd();
        bit found;
        found = 1'b0;
        issue(35, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.MemRead && ifc.IorD) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_memrd", int'(found), 1);
        #2 rst = 1'b1;
        #1 chk("rst_async_gate",
               int'({ifc.PCWrite, ifc.IRWrite, ifc.RegWrite, ifc.MemWrite,
                     ifc.HiLoWrite, ifc.done}), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_release_fetch",
               int'({ifc.MemRead, ifc.IRWrite, ifc.PCWrite}), 7);
    endtask

    int ops[13]   = '{0, 0, 0, 35, 43, 8, 10, 4, 5, 2, 3, 15, 63};
    int funcs[11] = '{32, 34, 36, 37, 38, 42, 24, 26, 16, 18, 8};

    initial begin
        int op, fn;
        bit drained;
        rst = 1'b1;
        ifc.opcode = '0;
        ifc.func   = '0;
        ifc.zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("reset_first_fetch",
               int'({ifc.MemRead, ifc.IRWrite, ifc.PCWrite}), 7);

        // Directed sequence
        issue(35, 0, 1'b0);   // lw
        issue(0, 32, 1'b0);   // add
        issue(0, 24, 1'b0);   // mult
        issue(4, 0, 1'b1);    // beq taken
        issue(5, 0, 1'b1);    // bne not taken
        issue(3, 0, 1'b0);    // jal
        issue(0, 8, 1'b0);    // jr
        issue(63, 0, 1'b0);   // illegal opcode
        reset_mid_memrd();

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 12)];
            if (op == 63) op = int'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) fn = int'($urandom_range(0, 63));
            else fn = funcs[$urandom_range(0, 10)];
            issue(op, fn, 1'($urandom_range(0, 1)));
        end

        drained = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("scoreboard_drained", int'(drained), 1);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multi-cycle variant of the MIPS-subset CPU. It replaces the single-cycle decoder with a Moore FSM that shares one memory port and one ALU across fetch, address, execute and write-back steps. It sits beside the multi-cycle datapath (PC, IR, MDR, A/B, ALUOut, HI/LO registers) and drives every enable and mux select there.

## Interface

No parameters.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag, combinational from current ALU operands
- PCWrite  out  1  PC load enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register-file write enable
- RegDst  out  1  1 = rd, 0 = rt; ignored when IsJal = 1 (writes $31)
- MemToReg  out  1  1 = MDR, 0 = ALUOut
- IsJal  out  1  write-data = PC (return address), destination = $31
- IsLui  out  1  write-data = imm << 16
- HiLoWrite  out  1  HI/LO load enable
- ALUsrcA  out  1  0 = PC, 1 = A
- ALUsrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUop  out  4  0 add, 1 sub, 2 or, 3 and, 4 xor, 5 slt, 6 mult, 7 mfhi, 8 mflo, 9 div
- PCselect  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = A (jr), 11 = jump target
- done  out  1  high in the final cycle of every instruction

## Operation

- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, IMMEX, IMMWB, BRANCH, JUMP, JAL, JR, LUI. Every output is 0 unless listed for the current state.
- FETCH: MemRead, IRWrite, PCWrite; IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=0, PCselect=00. Always → DECODE.
- DECODE: ALUsrcA=0, ALUsrcB=11, ALUop=0 (branch target into ALUOut). Next state: opcode 35/43 → MEMADR; 0 with func 32/34/36/37/38/42/24/26/16/18 → EXEC; 0 with func 8 → JR; 8/10 → IMMEX; 4/5 → BRANCH; 2 → JUMP; 3 → JAL; 15 → LUI; any other opcode/func → FETCH with done=1 (NOP).
- MEMADR: ALUsrcA=1, ALUsrcB=10, ALUop=0; → MEMRD (35) or MEMWR (43).
- MEMRD: MemRead, IorD=1 → MEMWB. MEMWB: RegWrite, RegDst=0, MemToReg=1, done → FETCH.
- MEMWR: MemWrite, IorD=1, done → FETCH.
- EXEC: ALUsrcA=1, ALUsrcB=00, ALUop from func (32→0, 34→1, 36→3, 37→2, 38→4, 42→5, 24→6, 26→9, 16→7, 18→8). func 24/26: HiLoWrite, done → FETCH. Others → RWB.
- RWB: RegWrite, RegDst=1, MemToReg=0, ALUop held as in EXEC, done → FETCH.
- IMMEX: ALUsrcA=1, ALUsrcB=10, ALUop=0 (addi) or 5 (slti) → IMMWB. IMMWB: RegWrite, RegDst=0, done → FETCH.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUop=1, PCselect=01; PCWrite = zero (opcode 4) or ~zero (opcode 5); done → FETCH.
- JUMP: PCWrite, PCselect=11, done → FETCH.
- JAL: RegWrite, IsJal, PCWrite, PCselect=11, done → FETCH (PC already holds PC+4).
- JR: PCWrite, PCselect=10, done → FETCH.
- LUI: RegWrite, RegDst=0, IsLui, done → FETCH.

## Timing

- State register updates on rising clk; outputs decode from state (plus opcode/func/zero where stated) combinationally.
- Cycles per instruction: lw 5; sw, R-type ALU, mfhi/mflo, addi, slti 4; mult, div, beq, bne, j, jal, jr, lui 3; NOP 2.
- opcode/func valid from DECODE until return to FETCH (IR stable since IRWrite only in FETCH).
- Reset: state → FETCH immediately on rst rise; while rst=1, PCWrite, IRWrite, RegWrite, MemWrite, HiLoWrite, done forced 0. First fetch occurs on the first clk edge after rst falls. Reset mid-instruction abandons it; no partial write after rst asserts.
- zero sampled only in BRANCH, same cycle as PCWrite.

## Structure

- Shared package: state enum, opcode and func constants, ALUop codes, ALUsrcB and PCselect encodings; single-cycle controller reuses the same constants.
- One sub-module: alu_func_decode (func → ALUop, plus is_hilo flag), instanced once, used in EXEC/RWB.

## Test plan

- Reset held 3 cycles mid-MEMRD, release → state FETCH, no RegWrite, first cycle after release shows MemRead=1, IRWrite=1, PCWrite=1.
- lw (opcode 35) → FETCH, DECODE, MEMADR, MEMRD, MEMWB; MemToReg=1 and RegWrite=1 only in cycle 5; done pulses once.
- R add (0/32) then mult (0/24) → add 4 cycles with RegWrite in RWB, RegDst=1, ALUop=0; mult 3 cycles, HiLoWrite=1, RegWrite never 1.
- beq with zero=1 and bne with zero=1 → beq PCWrite=1, PCselect=01 in cycle 3; bne PCWrite=0.
- jal then jr (0/8) → JAL asserts RegWrite, IsJal, PCselect=11; JR asserts PCWrite, PCselect=10, RegWrite=0.
- Illegal opcode 63 → two cycles, done in DECODE, no write enable asserted, next cycle FETCH.
